decode_issue_ctrl: RTL and testbench
====================================

DECODE_ISSUE_CTRL -- requirements
Module: decode_issue_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-high reset: 1 = reset, despite the suffix.
REQ-003 SHALL have port flush, input, 1, branch/redirect flush.
REQ-004 SHALL have ports fetch_valid (input, 2, [0]=slot A, [1]=slot B), fetch_instA/fetch_instB (input, 32 each) and fetch_pcA/fetch_pcB (input, 32 each).
REQ-005 SHALL have port fetch_ready, output, 1, queue can accept a 2-instruction push.
REQ-006 SHALL have ports dec_instA, dec_instB, dec_pcA, dec_pcB, output, 32 each, to the decoder instA/instB/pcA/pcB.
REQ-007 SHALL have ports dec_validA and dec_validB, output, 1 each, slot issued this cycle.
REQ-008 SHALL have decoder feedback inputs, 1 each: error_A, error_B, fence_A, fence_B, ecall_A, ecall_B, ebreak_A, ebreak_B, jump_A.
REQ-009 SHALL have inputs dispatch_ready (1, downstream accepts issue), pipe_empty (1, no instruction in flight past decode) and trap_ack (1).
REQ-010 SHALL have outputs trap_req (1), trap_cause (2: 01 ecall, 10 ebreak, 11 illegal) and trap_pc (32).

Function
REQ-011 SHALL hold a 4-entry circular queue of {inst, pc}, with 2-bit head/tail pointers wrapping 3->0 and a 3-bit count of 0..4.
REQ-012 SHALL drive fetch_ready = (count <= 2) from registered state only, with no dependence on the current cycle's pop.
REQ-013 SHALL push when fetch_ready and not flush: 2'b11 pushes A then B; 2'b01 pushes A; 2'b10 and 2'b00 push nothing.
REQ-014 SHALL drive dec_instA/dec_pcA from the head entry and dec_instB/dec_pcB from head+1, combinationally; an empty slot SHALL read 0.
REQ-015 SHALL have states RUN, DRAIN and TRAP.
REQ-016 A serializing instruction SHALL be one with error, fence, ecall or ebreak set.
REQ-017 In RUN, dec_validA SHALL = count>=1 AND slot A not serializing.
REQ-018 In RUN, dec_validB SHALL = dec_validA AND count>=2 AND slot B not serializing AND !jump_A.
REQ-019 In RUN with count>=1 and slot A serializing, the block SHALL issue nothing and go to DRAIN next cycle.
REQ-020 Pop SHALL be dec_validA+dec_validB when dispatch_ready=1, and 0 otherwise; count next = count + push - pop, with push and pop in the same cycle allowed.
REQ-021 In DRAIN with pipe_empty=0, the block SHALL issue nothing.
REQ-022 In DRAIN with pipe_empty=1 and head a fence (no error/ecall/ebreak), dec_validA SHALL assert alone; on dispatch_ready it SHALL pop 1 and return to RUN.
REQ-023 In DRAIN with pipe_empty=1 and head error/ecall/ebreak, the block SHALL go to TRAP next cycle.
REQ-024 In TRAP, trap_req SHALL = 1; trap_cause SHALL take priority error(11) > ebreak(10) > ecall(01); trap_pc SHALL = head pc; there SHALL be no issue.
REQ-025 trap_req, trap_cause and trap_pc SHALL stay stable until trap_ack.
REQ-026 On trap_ack in TRAP, the queue SHALL be cleared (count 0, head=tail=0) and the state SHALL return to RUN next cycle.
REQ-027 flush SHALL have the highest priority: next cycle, count=0, head=tail=0, state=RUN and trap_req=0; the same-cycle push is discarded.
REQ-028 During a flush cycle, dec_validA/B SHALL be 0 and the same-cycle trap_ack SHALL be ignored.
REQ-029 Count SHALL never exceed 4 or underflow below 0; an illegal combination SHALL leave count unchanged.

Reset
REQ-030 While rst_n=1, asynchronously: state=RUN, count=0, head=tail=0, trap_req=0, trap_cause=0, trap_pc=0, dec_validA/B=0, dec_inst*/dec_pc*=0, fetch_ready=1.
REQ-031 Reset asserted mid-DRAIN or mid-TRAP SHALL discard all queue contents; the first cycle after deassertion SHALL behave as RUN with an empty queue.

Verification
REQ-032 Bench SHALL cover: push two ADDs (pc 0x100, 0x104), dispatch_ready=1 -> next cycle dec_validA=dec_validB=1, dec_pcA=0x100, dec_pcB=0x104; count returns to 0.
REQ-033 Bench SHALL cover: dispatch_ready=0, push 2 then 2 -> count=4, fetch_ready=0; a third push is ignored; pop 2 -> fetch_ready=1.
REQ-034 Bench SHALL cover: head fence, pipe_empty=0 for 3 cycles, then 1 -> no issue for 3 cycles, then dec_validA=1 alone, dec_validB=0; back to RUN.
REQ-035 Bench SHALL cover: head ecall at pc 0x200, pipe_empty=1 -> TRAP: trap_req=1, trap_cause=01, trap_pc=0x200 held until trap_ack; then count=0.
REQ-036 Bench SHALL cover: slot B ebreak, slot A ADD -> A issued alone; the next cycle ebreak is at head and moves to DRAIN.
REQ-037 Bench SHALL cover: flush asserted in TRAP with push 2'b11 and trap_ack both high -> next cycle count=0, trap_req=0, state RUN.
REQ-038 Bench SHALL cover: jump_A=1 with count=2 -> dec_validB=0 and pop 1.

Source files
------------

// File: rtl/decode_issue_ctrl.sv
// -----------------------------------------------------------------------------
// decode_issue_ctrl
// Dual-slot decode/issue controller. Fetched instruction pairs are held in a
// 4-entry circular queue. The head and head+1 entries are shown to the decoder
// every cycle. Serializing instructions (error, fence, ecall, ebreak) at the
// head stall issue until the pipeline has drained. A fence then issues alone.
// A trapping instruction raises a held trap request until it is acknowledged.
//
// Ports
//   clk                 rising-edge clock
//   rst_n               asynchronous reset, ACTIVE-HIGH despite the name
//   flush               branch/redirect flush (highest priority)
//   fetch_valid[1:0]    [0]=slot A, [1]=slot B; only 2'b01 and 2'b11 push
//   fetch_inst*/pc*     fetched instruction words and their PCs
//   fetch_ready         queue can take a 2-instruction push (count <= 2)
//   dec_inst*/dec_pc*   head / head+1 entries to the decoder (0 when empty)
//   dec_valid*          slot issued this cycle
//   error_*, fence_*, ecall_*, ebreak_*, jump_A   decoder feedback
//   dispatch_ready      downstream accepts the issued slots
//   pipe_empty          nothing in flight past decode
//   trap_ack            acknowledges an outstanding trap request
//   trap_req/cause/pc   held trap request; cause 01 ecall, 10 ebreak, 11 illegal
// -----------------------------------------------------------------------------
module decode_issue_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic [1:0]  fetch_valid,
   input  logic [31:0] fetch_instA,
   input  logic [31:0] fetch_instB,
   input  logic [31:0] fetch_pcA,
   input  logic [31:0] fetch_pcB,
   output logic        fetch_ready,
   output logic [31:0] dec_instA,
   output logic [31:0] dec_instB,
   output logic [31:0] dec_pcA,
   output logic [31:0] dec_pcB,
   output logic        dec_validA,
   output logic        dec_validB,
   input  logic        error_A,
   input  logic        error_B,
   input  logic        fence_A,
   input  logic        fence_B,
   input  logic        ecall_A,
   input  logic        ecall_B,
   input  logic        ebreak_A,
   input  logic        ebreak_B,
   input  logic        jump_A,
   input  logic        dispatch_ready,
   input  logic        pipe_empty,
   input  logic        trap_ack,
   output logic        trap_req,
   output logic [1:0]  trap_cause,
   output logic [31:0] trap_pc
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_TRAP  = 2'd2
   } state_e;

   // Any of these forces the pipeline to drain before the instruction proceeds.
   function automatic logic is_serializing(input logic err, input logic fen,
                                           input logic ecl, input logic ebr);
      return err | fen | ecl | ebr;
   endfunction

   // Trap cause priority: illegal > ebreak > ecall.
   function automatic logic [1:0] trap_cause_enc(input logic err, input logic ebr,
                                                 input logic ecl);
      logic [1:0] c;
      if (err) begin
         c = 2'b11;
      end else if (ebr) begin
         c = 2'b10;
      end else if (ecl) begin
         c = 2'b01;
      end else begin
         c = 2'b00;
      end
      return c;
   endfunction

   state_e      state_q, state_d;
   logic [31:0] inst_q [4];
   logic [31:0] pc_q   [4];
   logic [1:0]  head_q, head_d;
   logic [1:0]  tail_q, tail_d;
   logic [2:0]  count_q, count_d;
   logic        trap_req_q, trap_req_d;
   logic [1:0]  trap_cause_q, trap_cause_d;
   logic [31:0] trap_pc_q, trap_pc_d;

   logic        ser_a_s, ser_b_s;
   logic        valid_a_s, valid_b_s;
   logic        clear_s;
   logic [1:0]  push_cnt_s, pop_cnt_s;
   logic [3:0]  cnt_sum_s;
   logic        upd_ok_s;
   logic        wr_a_s, wr_b_s;
   logic [1:0]  head_p1_s, tail_p1_s;

   assign head_p1_s = head_q + 2'd1;
   assign tail_p1_s = tail_q + 2'd1;
   assign ser_a_s   = is_serializing(error_A, fence_A, ecall_A, ebreak_A);
   assign ser_b_s   = is_serializing(error_B, fence_B, ecall_B, ebreak_B);

   // Acceptance depends only on registered occupancy, never on this cycle's pop.
   assign fetch_ready = (count_q <= 3'd2);

   // Decoder view: head and head+1, zero when the slot holds nothing.
   always_comb begin
      dec_instA = 32'd0;
      dec_pcA   = 32'd0;
      dec_instB = 32'd0;
      dec_pcB   = 32'd0;
      if (count_q >= 3'd1) begin
         dec_instA = inst_q[head_q];
         dec_pcA   = pc_q[head_q];
      end else begin
         dec_instA = 32'd0;
         dec_pcA   = 32'd0;
      end
      if (count_q >= 3'd2) begin
         dec_instB = inst_q[head_p1_s];
         dec_pcB   = pc_q[head_p1_s];
      end else begin
         dec_instB = 32'd0;
         dec_pcB   = 32'd0;
      end
   end

   // Issue FSM: next state, issue strobes, trap capture and queue clear.
   always_comb begin
      state_d      = state_q;
      valid_a_s    = 1'b0;
      valid_b_s    = 1'b0;
      clear_s      = 1'b0;
      trap_req_d   = trap_req_q;
      trap_cause_d = trap_cause_q;
      trap_pc_d    = trap_pc_q;
      if (flush) begin
         state_d      = ST_RUN;
         clear_s      = 1'b1;
         trap_req_d   = 1'b0;
         trap_cause_d = 2'b00;
         trap_pc_d    = 32'd0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (count_q >= 3'd1) begin
                  if (ser_a_s) begin
                     state_d = ST_DRAIN;
                  end else begin
                     valid_a_s = 1'b1;
                     // A taken jump in A means B is on the wrong path.
                     valid_b_s = (count_q >= 3'd2) && !ser_b_s && !jump_A;
                  end
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_DRAIN: begin
               if (count_q == 3'd0) begin
                  state_d = ST_RUN;
               end else if (pipe_empty) begin
                  if (error_A || ecall_A || ebreak_A) begin
                     state_d      = ST_TRAP;
                     trap_req_d   = 1'b1;
                     trap_cause_d = trap_cause_enc(error_A, ebreak_A, ecall_A);
                     trap_pc_d    = dec_pcA;
                  end else if (fence_A) begin
                     valid_a_s = 1'b1;
                     if (dispatch_ready) begin
                        state_d = ST_RUN;
                     end else begin
                        state_d = ST_DRAIN;
                     end
                  end else begin
                     state_d = ST_RUN;
                  end
               end else begin
                  state_d = ST_DRAIN;
               end
            end
            ST_TRAP: begin
               if (trap_ack) begin
                  state_d      = ST_RUN;
                  clear_s      = 1'b1;
                  trap_req_d   = 1'b0;
                  trap_cause_d = 2'b00;
                  trap_pc_d    = 32'd0;
               end else begin
                  state_d = ST_TRAP;
               end
            end
            default: begin
               state_d    = ST_RUN;
               clear_s    = 1'b1;
               trap_req_d = 1'b0;
            end
         endcase
      end
   end

   assign dec_validA = valid_a_s;
   assign dec_validB = valid_b_s;

   // Queue bookkeeping: push/pop amounts, pointer and occupancy update.
   always_comb begin
      push_cnt_s = 2'd0;
      pop_cnt_s  = 2'd0;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      wr_a_s     = 1'b0;
      wr_b_s     = 1'b0;
      upd_ok_s   = 1'b0;
      if (fetch_ready && !flush) begin
         case (fetch_valid)
            2'b11:   push_cnt_s = 2'd2;
            2'b01:   push_cnt_s = 2'd1;
            default: push_cnt_s = 2'd0;
         endcase
      end else begin
         push_cnt_s = 2'd0;
      end
      if (dispatch_ready) begin
         pop_cnt_s = {1'b0, valid_a_s} + {1'b0, valid_b_s};
      end else begin
         pop_cnt_s = 2'd0;
      end
      cnt_sum_s = {1'b0, count_q} + {2'b00, push_cnt_s} - {2'b00, pop_cnt_s};
      if (clear_s) begin
         head_d  = 2'd0;
         tail_d  = 2'd0;
         count_d = 3'd0;
      end else if (({1'b0, pop_cnt_s} > count_q) || (cnt_sum_s > 4'd4)) begin
         // Inconsistent request: keep the queue exactly as it is.
         upd_ok_s = 1'b0;
      end else begin
         upd_ok_s = 1'b1;
         wr_a_s   = (push_cnt_s >= 2'd1);
         wr_b_s   = (push_cnt_s == 2'd2);
         head_d   = head_q + pop_cnt_s;
         tail_d   = tail_q + push_cnt_s;
         count_d  = cnt_sum_s[2:0];
      end
   end

   // State, pointer and trap registers.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q      <= ST_RUN;
         head_q       <= 2'd0;
         tail_q       <= 2'd0;
         count_q      <= 3'd0;
         trap_req_q   <= 1'b0;
         trap_cause_q <= 2'b00;
         trap_pc_q    <= 32'd0;
      end else begin
         state_q      <= state_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         trap_req_q   <= trap_req_d;
         trap_cause_q <= trap_cause_d;
         trap_pc_q    <= trap_pc_d;
      end
   end

   // Queue storage; slot A lands at tail, slot B at tail+1.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++) begin
            inst_q[i] <= 32'd0;
            pc_q[i]   <= 32'd0;
         end
      end else begin
         if (wr_a_s) begin
            inst_q[tail_q] <= fetch_instA;
            pc_q[tail_q]   <= fetch_pcA;
         end
         if (wr_b_s) begin
            inst_q[tail_p1_s] <= fetch_instB;
            pc_q[tail_p1_s]   <= fetch_pcB;
         end
      end
   end

   assign trap_req   = trap_req_q;
   assign trap_cause = trap_cause_q;
   assign trap_pc    = trap_pc_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_decode_issue_ctrl
// Bench for decode_issue_ctrl. Instruction words carry their class in bits
// [2:0] (0 ADD, 1 fence, 2 ecall, 3 ebreak, 4 illegal, 5 jump); the bench's
// decoder stub turns the presented words into feedback flags. A reference
// model keeps the queue as a list of entries and pushes one expected output
// record per cycle; the monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_decode_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [1:0]  fetch_valid = 2'b00;
   logic [31:0] fetch_instA = 32'd0, fetch_instB = 32'd0;
   logic [31:0] fetch_pcA = 32'd0, fetch_pcB = 32'd0;
   logic        fetch_ready;
   logic [31:0] dec_instA, dec_instB, dec_pcA, dec_pcB;
   logic        dec_validA, dec_validB;
   logic        error_A, error_B, fence_A, fence_B, ecall_A, ecall_B;
   logic        ebreak_A, ebreak_B, jump_A;
   logic        dispatch_ready = 1'b0, pipe_empty = 1'b0, trap_ack = 1'b0;
   logic        trap_req;
   logic [1:0]  trap_cause;
   logic [31:0] trap_pc;

   always #5 clk = ~clk;

   decode_issue_ctrl dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .fetch_valid(fetch_valid),
      .fetch_instA(fetch_instA), .fetch_instB(fetch_instB),
      .fetch_pcA(fetch_pcA), .fetch_pcB(fetch_pcB), .fetch_ready(fetch_ready),
      .dec_instA(dec_instA), .dec_instB(dec_instB),
      .dec_pcA(dec_pcA), .dec_pcB(dec_pcB),
      .dec_validA(dec_validA), .dec_validB(dec_validB),
      .error_A(error_A), .error_B(error_B), .fence_A(fence_A), .fence_B(fence_B),
      .ecall_A(ecall_A), .ecall_B(ecall_B), .ebreak_A(ebreak_A), .ebreak_B(ebreak_B),
      .jump_A(jump_A), .dispatch_ready(dispatch_ready), .pipe_empty(pipe_empty),
      .trap_ack(trap_ack), .trap_req(trap_req), .trap_cause(trap_cause),
      .trap_pc(trap_pc)
   );

   // Decoder stub: classify the words the DUT presents.
   assign fence_A  = (dec_instA[2:0] == 3'd1);
   assign ecall_A  = (dec_instA[2:0] == 3'd2);
   assign ebreak_A = (dec_instA[2:0] == 3'd3);
   assign error_A  = (dec_instA[2:0] == 3'd4);
   assign jump_A   = (dec_instA[2:0] == 3'd5);
   assign fence_B  = (dec_instB[2:0] == 3'd1);
   assign ecall_B  = (dec_instB[2:0] == 3'd2);
   assign ebreak_B = (dec_instB[2:0] == 3'd3);
   assign error_B  = (dec_instB[2:0] == 3'd4);

   typedef struct packed {
      logic        va, vb, fr, treq;
      logic [1:0]  tc;
      logic [31:0] tpc, ia, pa, ib, pb;
   } rec_t;

   typedef struct packed {
      logic [31:0] inst, pc;
   } ent_t;

   rec_t  exp_q [$];
   ent_t  mq [$];
   int    mst = 0;          // 0 run, 1 drain, 2 trap
   logic        mtreq = 1'b0;
   logic [1:0]  mtc = 2'b00;
   logic [31:0] mtpc = 32'd0;
   int    n_cmp = 0;
   int    n_mis = 0;
   int    cyc_no = 0;

   function automatic logic [31:0] mk(input int kind);
      logic [31:0] r;
      r = $urandom;
      return {r[31:3], 3'(kind)};
   endfunction

   function automatic bit is_ser(input logic [2:0] k);
      return (k >= 3'd1) && (k <= 3'd4);
   endfunction

   // Reference model: expected outputs for this cycle, then state update.
   task automatic model_cycle();
      rec_t e;
      int n, pops;
      logic [2:0] ka, kb;
      logic [31:0] hpc;
      if (rst_n) begin
         mq.delete(); mst = 0; mtreq = 1'b0; mtc = 2'b00; mtpc = 32'd0;
      end
      n   = mq.size();
      ka  = (n >= 1) ? mq[0].inst[2:0] : 3'd0;
      kb  = (n >= 2) ? mq[1].inst[2:0] : 3'd0;
      hpc = (n >= 1) ? mq[0].pc : 32'd0;
      e = '0;
      e.fr = (n <= 2);
      if (n >= 1) begin e.ia = mq[0].inst; e.pa = mq[0].pc; end
      if (n >= 2) begin e.ib = mq[1].inst; e.pb = mq[1].pc; end
      if (!flush && !rst_n) begin
         if (mst == 0) begin
            e.va = (n >= 1) && !is_ser(ka);
            e.vb = e.va && (n >= 2) && !is_ser(kb) && (ka != 3'd5);
         end else if (mst == 1) begin
            e.va = pipe_empty && (n >= 1) && (ka == 3'd1);
         end
      end
      e.treq = mtreq; e.tc = mtc; e.tpc = mtpc;
      exp_q.push_back(e);
      if (rst_n) return;
      if (flush) begin
         mq.delete(); mst = 0; mtreq = 1'b0; mtc = 2'b00; mtpc = 32'd0;
         return;
      end
      pops = dispatch_ready ? (int'(e.va) + int'(e.vb)) : 0;
      repeat (pops) void'(mq.pop_front());
      if (e.fr && fetch_valid[0]) begin
         mq.push_back('{inst: fetch_instA, pc: fetch_pcA});
         if (fetch_valid[1]) mq.push_back('{inst: fetch_instB, pc: fetch_pcB});
      end
      case (mst)
         0: if (n >= 1 && is_ser(ka)) mst = 1;
         1: begin
            if (n == 0) mst = 0;
            else if (pipe_empty) begin
               if (ka == 3'd2 || ka == 3'd3 || ka == 3'd4) begin
                  mst = 2; mtreq = 1'b1; mtpc = hpc;
                  mtc = (ka == 3'd4) ? 2'b11 : (ka == 3'd3) ? 2'b10 : 2'b01;
               end else if (ka == 3'd1) begin
                  if (dispatch_ready) mst = 0;
               end else mst = 0;
            end
         end
         default: if (trap_ack) begin
            mq.delete(); mst = 0; mtreq = 1'b0; mtc = 2'b00; mtpc = 32'd0;
         end
      endcase
   endtask

   // One cycle: inputs already driven; settle, predict, advance the clock.
   task automatic cyc();
      #1;
      model_cycle();
      @(posedge clk);
      #1;
      cyc_no++;
   endtask

   task automatic idle_inputs();
      flush = 1'b0; fetch_valid = 2'b00; trap_ack = 1'b0;
   endtask

   task automatic push2(input int ka, input logic [31:0] pa, input int kb,
                        input logic [31:0] pb);
      fetch_valid = 2'b11;
      fetch_instA = mk(ka); fetch_pcA = pa;
      fetch_instB = mk(kb); fetch_pcB = pb;
   endtask

   // Monitor: compare the DUT against the oldest expected record.
   always @(negedge clk) begin
      rec_t e, g;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = '{va: dec_validA, vb: dec_validB, fr: fetch_ready, treq: trap_req,
               tc: trap_cause, tpc: trap_pc, ia: dec_instA, pa: dec_pcA,
               ib: dec_instB, pb: dec_pcB};
         n_cmp++;
         if (g !== e) begin
            n_mis++;
            $display("FAIL cycle_%0d: got vA=%b vB=%b fr=%b treq=%b tc=%b tpc=%h pcA=%h pcB=%h iA=%h iB=%h | want vA=%b vB=%b fr=%b treq=%b tc=%b tpc=%h pcA=%h pcB=%h iA=%h iB=%h",
                     cyc_no, g.va, g.vb, g.fr, g.treq, g.tc, g.tpc, g.pa, g.pb, g.ia, g.ib,
                     e.va, e.vb, e.fr, e.treq, e.tc, e.tpc, e.pa, e.pb, e.ia, e.ib);
         end
      end
   end

   initial begin
      @(posedge clk); #1;
      // Reset state.
      rst_n = 1'b1; cyc(); cyc();
      rst_n = 1'b0;
      // Two ADDs, issued together next cycle.
      dispatch_ready = 1'b1; pipe_empty = 1'b1;
      push2(0, 32'h100, 0, 32'h104); cyc();
      idle_inputs(); cyc(); cyc();
      // Fill to 4 with no dispatch, third push ignored, then drain.
      dispatch_ready = 1'b0;
      push2(0, 32'h10, 0, 32'h14); cyc();
      push2(0, 32'h18, 0, 32'h1c); cyc();
      push2(0, 32'h20, 0, 32'h24); cyc();
      idle_inputs(); dispatch_ready = 1'b1; cyc(); cyc(); cyc();
      // Fence at head, pipeline busy for three cycles.
      pipe_empty = 1'b0; push2(1, 32'h30, 0, 32'h34); cyc();
      idle_inputs(); cyc(); cyc(); cyc(); cyc();
      pipe_empty = 1'b1; cyc(); cyc(); cyc();
      // Ecall at 0x200 traps and holds until acknowledged.
      fetch_valid = 2'b01; fetch_instA = mk(2); fetch_pcA = 32'h200; cyc();
      idle_inputs(); cyc(); cyc(); cyc(); cyc(); cyc();
      trap_ack = 1'b1; cyc(); idle_inputs(); cyc();
      // ADD then ebreak: A alone, then ebreak drains and traps.
      push2(0, 32'h300, 3, 32'h304); cyc();
      idle_inputs(); cyc(); cyc(); cyc(); cyc();
      // Flush in TRAP together with a push and trap_ack.
      flush = 1'b1; trap_ack = 1'b1; push2(0, 32'h400, 0, 32'h404); cyc();
      idle_inputs(); cyc();
      // Jump in slot A blocks slot B.
      push2(5, 32'h500, 0, 32'h504); cyc();
      idle_inputs(); cyc(); cyc(); cyc();
      // Illegal instruction, reset while in TRAP.
      fetch_valid = 2'b01; fetch_instA = mk(4); fetch_pcA = 32'h600; cyc();
      idle_inputs(); cyc(); cyc(); cyc();
      rst_n = 1'b1; cyc(); rst_n = 1'b0;
      push2(0, 32'h700, 0, 32'h704); cyc();
      idle_inputs(); cyc(); cyc();
      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         int k;
         flush          = ($urandom_range(0, 31) == 0);
         fetch_valid    = 2'($urandom_range(0, 3));
         k = $urandom_range(0, 15);
         fetch_instA    = mk((k < 9) ? 0 : k - 9 > 5 ? 0 : k - 9);
         k = $urandom_range(0, 15);
         fetch_instB    = mk((k < 9) ? 0 : k - 9 > 5 ? 0 : k - 9);
         fetch_pcA      = $urandom; fetch_pcB = $urandom;
         dispatch_ready = ($urandom_range(0, 3) != 0);
         pipe_empty     = ($urandom_range(0, 1) == 1);
         trap_ack       = ($urandom_range(0, 3) == 0);
         rst_n          = ($urandom_range(0, 199) == 0);
         cyc();
      end
      rst_n = 1'b0; idle_inputs(); cyc();
      @(negedge clk); #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_mis++;
         $display("FAIL drain_queue: %0d records left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
